print_arbiter: RTL and testbench

//  Shares one console output channel among the NCORES ALUs. Each cycle, a round-robin arbiter

---
 rtl/print_arbiter.sv | 123 ++++++++++++
 tb/tb_print_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/print_arbiter.sv
// print_arbiter: shares one console output channel among NCORES ALUs.
// A round-robin arbiter grants at most one PRINT request per cycle and
// pushes {core index, value} into a first-word-fall-through FIFO. The FIFO
// drains through a valid/ready interface. Every requester that is not
// granted is stalled so its ALU holds the PRINT instruction and value.
module print_arbiter #(
  parameter int NCORES     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CORE_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCORES-1:0]      print_valid,
  input  logic [NCORES*16-1:0]   print,
  output logic [NCORES-1:0]      core_stall,
  output logic                   out_valid,
  output logic [15:0]            out_data,
  output logic [CORE_W-1:0]      out_core,
  input  logic                   out_ready,
  output logic [CORE_W:0]        fifo_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CORE_W:0]   DEPTH_C = (CORE_W+1)'(FIFO_DEPTH);
  localparam logic [CORE_W-1:0] LAST_C  = CORE_W'(NCORES - 1);

  // Arbitration and FIFO state
  logic [CORE_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CORE_W:0]   r_count;
  logic [15:0]       r_mem_data [FIFO_DEPTH];
  logic [CORE_W-1:0] r_mem_core [FIFO_DEPTH];

  // Combinational arbitration results
  logic              w_accept;
  logic              w_hit_hi;
  logic              w_hit_any;
  logic [CORE_W-1:0] w_idx_hi;
  logic [CORE_W-1:0] w_idx_any;
  logic              w_grant;
  logic [CORE_W-1:0] w_gidx;
  logic [NCORES-1:0] w_gnt_vec;
  logic [15:0]       w_push_data;
  logic              w_pop;

  // Full check ignores same-cycle pop, keeping out_ready off the stall path.
  assign w_accept = !rst && (r_count < DEPTH_C);
  assign w_pop    = out_valid && out_ready;

  // Round-robin search: lowest requester at or above rr_ptr, else lowest
  // requester overall (the wrap-around part of the search).
  always_comb begin
    w_hit_hi  = 1'b0;
    w_hit_any = 1'b0;
    w_idx_hi  = '0;
    w_idx_any = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      if (print_valid[i] && !w_hit_any) begin
        w_hit_any = 1'b1;
        w_idx_any = CORE_W'(i);
      end
      if (print_valid[i] && !w_hit_hi && (32'(r_rr_ptr) <= i)) begin
        w_hit_hi = 1'b1;
        w_idx_hi = CORE_W'(i);
      end
    end
    w_grant = w_accept && w_hit_any;
    w_gidx  = w_hit_hi ? w_idx_hi : w_idx_any;
  end

  // Grant decode, stall generation and selection of the granted value
  always_comb begin
    w_gnt_vec   = '0;
    w_push_data = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      w_gnt_vec[i] = w_grant && (w_gidx == CORE_W'(i));
      if (w_gnt_vec[i]) begin
        w_push_data = print[i*16 +: 16];
      end
    end
  end

  assign core_stall = print_valid & ~w_gnt_vec;

  // FIFO head presentation; an empty FIFO shows zeros
  assign out_valid  = (r_count != '0);
  assign out_data   = out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign out_core   = out_valid ? r_mem_core[r_rd_ptr] : '0;
  assign fifo_count = r_count;

  // FIFO storage writes; contents need no reset since count gates validity
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_mem_data[r_wr_ptr] <= w_push_data;
      r_mem_core[r_wr_ptr] <= w_gidx;
    end
  end

  // Pointer, occupancy and round-robin state updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_grant) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= (w_gidx == LAST_C) ? '0 : w_gidx + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_grant, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_print_arbiter.sv
// tb_print_arbiter: directed scenarios plus randomized traffic, checked
// against a queue-based reference model of the arbiter and output FIFO.
module tb_print_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    print_valid = '0;
  logic [N*16-1:0] print = '0;
  logic [N-1:0]    core_stall;
  logic            out_valid;
  logic [15:0]     out_data;
  logic [CW-1:0]   out_core;
  logic            out_ready = 1'b0;
  logic [CW:0]     fifo_count;

  print_arbiter #(.NCORES(N), .FIFO_DEPTH(DEPTH), .CORE_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .print_valid(print_valid),
    .print      (print),
    .core_stall (core_stall),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_core   (out_core),
    .out_ready  (out_ready),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int core;
    int data;
  } ent_t;

  ent_t q[$];
  int   rr = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare against the
  // model's prediction, then advance the model to the coming rising edge.
  task automatic step(input logic [N-1:0] pv, input logic [N*16-1:0] pd, input logic rdy);
    logic [N-1:0] exp_stall;
    int g;
    @(negedge clk);
    print_valid = pv;
    print       = pd;
    out_ready   = rdy;
    #1;
    g = -1;
    if (q.size() < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && pv[(rr + k) % N]) g = (rr + k) % N;
      end
    end
    exp_stall = pv;
    if (g >= 0) exp_stall[g] = 1'b0;
    check_eq("stall", 32'(core_stall), 32'(exp_stall));
    check_eq("count", 32'(fifo_count), q.size());
    check_eq("valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check_eq("data", 32'(out_data), q[0].data);
      check_eq("core", 32'(out_core), q[0].core);
    end
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back('{g, int'(pd[g*16 +: 16])});
      rr = (g + 1) % N;
    end
  endtask

  // Asynchronous reset raised between clock edges
  task automatic mid_reset(input logic [N-1:0] pv);
    @(negedge clk);
    print_valid = pv;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_core", 32'(out_core), 32'd0);
    check_eq("rst_stall", 32'(core_stall), 32'(pv));
    q.delete();
    rr = 0;
    @(posedge clk);
    #1;
    check_eq("rst_hold_stall", 32'(core_stall), 32'(pv));
    check_eq("rst_hold_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    print_valid = '0;
    rst = 1'b0;
  endtask

  task automatic drain(input int cycles);
    for (int c = 0; c < cycles; c++) step('0, '0, 1'b1);
  endtask

  initial begin
    // Reset values while rst is held from time zero
    print_valid = 4'b0101;
    #3;
    check_eq("init_valid", 32'(out_valid), 32'd0);
    check_eq("init_count", 32'(fifo_count), 32'd0);
    check_eq("init_data", 32'(out_data), 32'd0);
    check_eq("init_core", 32'(out_core), 32'd0);
    check_eq("init_stall", 32'(core_stall), 32'h5);
    @(negedge clk);
    print_valid = '0;
    rst = 1'b0;

    // Single print from core 0
    step(4'b0001, 64'h0041, 1'b1);
    drain(2);

    // Bring rr to 0, then all four cores print; granted cores drop PRINT
    step(4'b1000, 64'h0000_0000_0000_0000 | (64'h0099 << 48), 1'b1);
    step(4'b1111, 64'h0013_0012_0011_0010, 1'b1);
    step(4'b1110, 64'h0013_0012_0011_0010, 1'b1);
    step(4'b1100, 64'h0013_0012_0011_0010, 1'b1);
    step(4'b1000, 64'h0013_0012_0011_0010, 1'b1);
    drain(5);

    // Backpressure: FIFO fills, one pop frees one slot
    for (int c = 0; c < 6; c++) step(4'b0110, 64'h0000_2222_1111_0000, 1'b0);
    step(4'b0110, 64'h0000_2222_1111_0000, 1'b1);
    step(4'b0110, 64'h0000_2222_1111_0000, 1'b0);
    step(4'b0110, 64'h0000_2222_1111_0000, 1'b0);
    drain(6);

    // Round-robin wrap: rr moved to 3, then cores 0 and 3 request
    step(4'b0100, 64'h0000_0300_0000_0000, 1'b1);
    step(4'b1001, 64'h0A03_0000_0000_0A00, 1'b1);
    step(4'b1001, 64'h0A03_0000_0000_0A00, 1'b1);
    drain(4);

    // Reset with three entries queued, then grants restart at core 0
    step(4'b0001, 64'h0000_0000_0000_00B0, 1'b0);
    step(4'b0010, 64'h0000_0000_00B1_0000, 1'b0);
    step(4'b0100, 64'h0000_00B2_0000_0000, 1'b0);
    mid_reset(4'b1010);
    step(4'b1111, 64'h00C3_00C2_00C1_00C0, 1'b1);
    step(4'b1111, 64'h00C3_00C2_00C1_00C0, 1'b1);
    drain(4);

    // Simultaneous push and pop at count 2
    step(4'b0001, 64'h0000_0000_0000_00D0, 1'b0);
    step(4'b0010, 64'h0000_0000_00D1_0000, 1'b0);
    step(4'b1000, 64'h00D3_0000_0000_0000, 1'b1);
    step('0, '0, 1'b0);
    drain(4);

    // Randomized traffic with varying backpressure and occasional resets
    for (int c = 0; c < 800; c++) begin
      logic [N-1:0]    pv;
      logic [N*16-1:0] pd;
      logic            rdy;
      pv  = N'($urandom);
      pd  = {$urandom, $urandom};
      rdy = ((c / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) mid_reset(pv);
      else step(pv, pd, rdy);
    end
    drain(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
